// File: rtl/sum_seq16.sv
// Sequential 16-bit adder: one nibble per cycle through a single 4-bit ripple adder.
// Optional subtraction (A-B via ~B and carry-in 1) is enabled by defining SUM_SEQ16_SUB_EN.

module sum4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [4:0] carry;

  assign carry[0] = c_in;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fa
      assign s[gi]         = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign c_out = carry[4];
endmodule

module sum_seq16 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        c_in,
`ifdef SUM_SEQ16_SUB_EN
  input  logic        op,
`endif
  output logic        busy,
  output logic        done,
  output logic [15:0] S,
  output logic        c_out
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t      state_reg;
  logic [1:0]  k_reg;
  logic        carry_reg;
  logic [15:0] a_reg;
  logic [15:0] b_reg;
  logic [15:0] s_reg;
  logic        c_out_reg;
  logic        busy_reg;
  logic        done_reg;

  logic [3:0]  nib_sel;
  logic [3:0]  add_s;
  logic        add_co;
  logic [15:0] b_load;
  logic        carry_load;

  assign nib_sel = {k_reg, 2'b00};

`ifdef SUM_SEQ16_SUB_EN
  // Subtraction reuses the adder as A + ~B + 1.
  assign b_load     = op ? ~B : B;
  assign carry_load = op ? 1'b1 : c_in;
`else
  assign b_load     = B;
  assign carry_load = c_in;
`endif

  sum4 u_sum4 (
    .a     (a_reg[nib_sel +: 4]),
    .b     (b_reg[nib_sel +: 4]),
    .c_in  (carry_reg),
    .s     (add_s),
    .c_out (add_co)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      k_reg     <= 2'd0;
      carry_reg <= 1'b0;
      a_reg     <= 16'h0000;
      b_reg     <= 16'h0000;
      s_reg     <= 16'h0000;
      c_out_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, FIN: begin
          done_reg <= 1'b0;
          if (start) begin
            a_reg     <= A;
            b_reg     <= b_load;
            carry_reg <= carry_load;
            k_reg     <= 2'd0;
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        RUN: begin
          s_reg[nib_sel +: 4] <= add_s;
          carry_reg           <= add_co;
          k_reg               <= k_reg + 2'd1;
          // The index wraps to 0 on the same edge that ends the run.
          if (k_reg == 2'd3) begin
            c_out_reg <= add_co;
            state_reg <= FIN;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign S     = s_reg;
  assign c_out = c_out_reg;
endmodule

// File: tb/tb_sum_seq16.sv
// Directed bench for sum_seq16; subtraction vectors run only when SUM_SEQ16_SUB_EN is defined.

module tb_sum_seq16;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        c_in;
`ifdef SUM_SEQ16_SUB_EN
  logic        op;
`endif
  logic        busy;
  logic        done;
  logic [15:0] S;
  logic        c_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sum_seq16 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .c_in    (c_in),
`ifdef SUM_SEQ16_SUB_EN
    .op      (op),
`endif
    .busy    (busy),
    .done    (done),
    .S       (S),
    .c_out   (c_out)
  );

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one start, mutate operands during RUN, and check busy for 4 cycles then done.
  task automatic run_and_check(input string name, input logic [15:0] a, input logic [15:0] b,
                               input logic ci, input logic [15:0] exp_s, input logic exp_co);
    A = a; B = b; c_in = ci; start = 1'b1;
    cycle();
    start = 1'b0;
    A = ~a; B = ~b; c_in = ~ci;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s run cycle %0d: busy=%b done=%b, required busy=1 done=0", name, i, busy, done);
      end
      cycle();
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || S !== exp_s || c_out !== exp_co) begin
      miscompares++;
      $display("FAIL %s result: done=%b busy=%b S=%h c_out=%b, required done=1 busy=0 S=%h c_out=%b",
               name, done, busy, S, c_out, exp_s, exp_co);
    end else
      $display("%s: A=%h B=%h c_in=%b -> S=%h c_out=%b", name, a, b, ci, S, c_out);
    cycle();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s after done: done=%b busy=%b, required 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; A = 16'hFFFF; B = 16'hFFFF; c_in = 1'b1;
    cycle();
    cycle();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || S !== 16'h0000 || c_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b S=%h c_out=%b, required 0 0 0000 0", busy, done, S, c_out);
    end else
      $display("reset: outputs cleared");
    reset_n = 1'b1; start = 1'b0;
    cycle();
  endtask

  task automatic test_add_basic();
    run_and_check("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
  endtask

  task automatic test_carry_ripple();
    run_and_check("carry_ripple", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
  endtask

  task automatic test_back_to_back();
    int n_done = 0;
    A = 16'h0001; B = 16'h0001; c_in = 1'b0; start = 1'b1;
    cycle();
    for (int n = 0; n < 15; n++) begin
      vectors++;
      if (done !== (n % 5 == 4) || busy !== (n % 5 != 4)) begin
        miscompares++;
        $display("FAIL back_to_back cycle %0d: done=%b busy=%b, required done=%b busy=%b",
                 n, done, busy, (n % 5 == 4), (n % 5 != 4));
      end
      if (done === 1'b1) begin
        n_done++;
        vectors++;
        if (S !== 16'h0002 || c_out !== 1'b0) begin
          miscompares++;
          $display("FAIL back_to_back result %0d: S=%h c_out=%b, required 0002 0", n_done, S, c_out);
        end else
          $display("back_to_back: result %0d S=%h at cycle %0d", n_done, S, n);
      end
      if (n < 14) cycle();
    end
    start = 1'b0;
    cycle();
    cycle();
    cycle();
    cycle();
    cycle();
    cycle();
  endtask

  task automatic test_reset_mid_run();
    A = 16'h0F0F; B = 16'h0101; c_in = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0; A = 16'hAAAA; B = 16'h5555;
    cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || S !== 16'h0000 || c_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_run: busy=%b done=%b S=%h c_out=%b, required 0 0 0000 0", busy, done, S, c_out);
    end else
      $display("reset_mid_run: aborted, outputs cleared");
    for (int i = 0; i < 6; i++) begin
      cycle();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_run idle %0d: done=%b busy=%b, required 0 0", i, done, busy);
      end
    end
    run_and_check("after_reset", 16'h0011, 16'h0022, 1'b0, 16'h0033, 1'b0);
  endtask

  task automatic test_overflow_hold();
    run_and_check("overflow", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      vectors++;
      if (S !== 16'h0000 || c_out !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL overflow hold %0d: S=%h c_out=%b done=%b, required 0000 1 0", i, S, c_out, done);
      end
    end
    $display("overflow: S held for 10 idle cycles");
  endtask

`ifdef SUM_SEQ16_SUB_EN
  task automatic test_sub();
    op = 1'b1;
    run_and_check("sub_borrow", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    run_and_check("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1);
    op = 1'b0;
  endtask
`endif

  initial begin
    reset_n = 1'b0; start = 1'b0; A = 16'h0000; B = 16'h0000; c_in = 1'b0;
`ifdef SUM_SEQ16_SUB_EN
    op = 1'b0;
`endif
    cycle();
    test_reset();
    test_add_basic();
    test_carry_ripple();
    test_back_to_back();
    test_reset_mid_run();
    test_overflow_hold();
`ifdef SUM_SEQ16_SUB_EN
    test_sub();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sum_seq16.md
SUM_SEQ16 -- requirements
Module: sum_seq16

Interface
REQ-001 The block SHALL have these ports:
- clk  input  1  rising-edge clock, sole clock.
- reset_n  input  1  reset, synchronous, active-low.
- start  input  1  request a new 16-bit operation; accepted only when busy=0.
- A  input  16  operand A; sampled on accepted start.
- B  input  16  operand B; sampled on accepted start.
- c_in  input  1  carry-in; sampled on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when S and c_out become valid.
- S  output  16  result; held stable from done until the next accepted start.
- c_out  output  1  carry-out of bit 15; held like S.
REQ-002 The block SHALL contain exactly one instance of the team's 4-bit structural adder (sum4); all arithmetic SHALL pass through it, with no other adder.

Function
REQ-003 The FSM SHALL have three states: IDLE, RUN and FIN.
- IDLE->RUN on start=1.
- RUN->FIN after nibble index 3 is processed.
- FIN->RUN on start=1, else FIN->IDLE.
REQ-004 On an accepted start, the block SHALL latch A, B and c_in, clear the nibble index to 0, and load the carry register with c_in.
REQ-005 In RUN, each cycle SHALL feed nibble k of the latched A and B plus the carry register to sum4. It SHALL write the sum4 S output into S[4k+3:4k], store the sum4 c_out into the carry register, and increment k.
REQ-006 Index k SHALL be 2 bits and wrap 3->0; the wrap coincides with the RUN->FIN transition.
REQ-007 busy SHALL be 1 in RUN and 0 in IDLE and FIN.
REQ-008 done SHALL be 1 only in FIN.
REQ-009 c_out SHALL take the carry register value produced at k=3.
REQ-010 Latency: with start high at rising edge t, the FSM SHALL be in RUN after t; RUN SHALL last 4 cycles; done SHALL be high in the cycle after edge t+4.
REQ-011 While in FIN, start=1 SHALL be accepted exactly as from IDLE, giving back-to-back throughput of one result per 5 cycles.
REQ-012 start while busy=1 SHALL be ignored. Changes to A, B or c_in while busy=1 SHALL NOT affect the result in progress.
REQ-013 S and c_out SHALL hold their values in IDLE and FIN. During RUN, nibbles of S not yet written SHALL keep their previous values.
REQ-014 Results SHALL be modulo 2^16 plus c_out, with no saturation.

Reset
REQ-015 reset_n=0 sampled at a rising edge SHALL force: state IDLE, k=0, carry register 0, latched operands 0, S=0, c_out=0, busy=0, done=0.
REQ-016 Reset SHALL take priority over start, including a reset asserted mid-RUN. The aborted operation SHALL produce no done pulse.

Configuration
REQ-017 The macro SUM_SEQ16_SUB_EN SHALL control subtraction support.
- Defined: add input port op (1 bit, sampled on accepted start). op=1 SHALL latch ~B and force the initial carry to 1, ignoring c_in, so S = A-B mod 2^16 and c_out=1 means no borrow. op=0 behaves as in REQ-004.
- Undefined: port op does not exist; behaviour is as REQ-001..REQ-016.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset, then A=16'h1234, B=16'h4321, c_in=0, start pulse -> busy high 4 cycles, done 5th cycle, S=16'h5555, c_out=0.
- A=16'hFFFF, B=16'h0000, c_in=1 -> S=16'h0000, c_out=1 (carry ripples through all 4 nibbles).
- start held high continuously, A=16'h0001, B=16'h0001 -> done every 5th cycle, S=16'h0002; starts during busy produce no extra operations.
- start, then A/B changed during RUN, then reset_n=0 at 2nd RUN cycle -> no done, all outputs 0, next start works normally.
- A=16'h8000, B=16'h8000, c_in=0 -> S=16'h0000, c_out=1; S then holds through 10 idle cycles.
- With SUB_EN: op=1, A=16'h0005, B=16'h0007 -> S=16'hFFFE, c_out=0; with A=16'h0007, B=16'h0005 -> S=16'h0002, c_out=1.
